// File: rtl/feed_from_mem_stream.sv
// Reads a block of wide memory words one request at a time and scatters their
// little-endian sub-bytes into a bank of FIFOs, sequentially or interleaved.
module feed_from_mem_stream #(
  parameter int NUM_FIFOS  = 9,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  fill,
  input  logic                  mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [MEM_WIDTH-1:0]  mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic [NUM_FIFOS-1:0]  fifo_full,
  output logic [DATA_WIDTH-1:0] dataByte,
  output logic [NUM_FIFOS-1:0]  fifoEnable,
  output logic                  busy,
  output logic                  done
);
  localparam int BPW   = MEM_WIDTH / DATA_WIDTH;
  localparam int TOTAL = NUM_FIFOS * DEPTH;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int SW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW    = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, DONE} state_t;

  state_t                            state;
  logic                              mode_r;
  logic [BW-1:0]                     b;
  logic [SW-1:0]                     sel;
  logic [TW-1:0]                     tgt;
  logic [DW-1:0]                     dcnt;
  logic [BPW-1:0][DATA_WIDTH-1:0]    wbuf;
  logic                              last_byte, last_in_word, wr;

  always_comb begin
    last_byte    = (b == BW'(TOTAL - 1));
    last_in_word = (sel == SW'(BPW - 1)) || last_byte;
    wr           = (state == UNPACK) && !fifo_full[tgt];
    dataByte     = '0;
    fifoEnable   = '0;
    if (state == UNPACK) begin
      dataByte        = wbuf[sel];
      fifoEnable[tgt] = ~fifo_full[tgt];
    end
  end

  // Target is tracked incrementally: a wrap counter when interleaved, a
  // per-FIFO fill counter when sequential.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_r   <= 1'b0;
      b        <= '0;
      sel      <= '0;
      tgt      <= '0;
      dcnt     <= '0;
      wbuf     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (fill) begin
          mem_addr <= addr;
          mode_r   <= mode;
          b        <= '0;
          sel      <= '0;
          tgt      <= '0;
          dcnt     <= '0;
          mem_read <= 1'b1;
          busy     <= 1'b1;
          state    <= REQ;
        end
        REQ: if (!mem_waitrequest) begin
          mem_read <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (mem_readdatavalid) begin
          wbuf  <= mem_readdata;
          state <= UNPACK;
        end
        UNPACK: if (wr) begin
          b   <= b + 1'b1;
          sel <= sel + 1'b1;
          if (mode_r) tgt <= (tgt == TW'(NUM_FIFOS - 1)) ? '0 : tgt + 1'b1;
          else if (dcnt == DW'(DEPTH - 1)) begin
            dcnt <= '0;
            tgt  <= tgt + 1'b1;
          end else dcnt <= dcnt + 1'b1;
          if (last_byte) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (last_in_word) begin
            sel      <= '0;
            mem_read <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
            state    <= REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feed_from_mem_stream.sv
// Bench for feed_from_mem_stream: default instance plus a 3x5 partial-word instance,
// each driven by a latency-1 memory responder and checked against a write-order model.
module tb_feed_from_mem_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory image: byte j of word a is (8a + j) mod 256.
  function automatic logic [63:0] memword(input logic [31:0] a);
    logic [31:0] t;
    memword = '0;
    for (int j = 0; j < 8; j++) begin
      t = a * 8 + j;
      memword[8*j +: 8] = t[7:0];
    end
  endfunction

  // ---------------- default instance ----------------
  logic [31:0] a0_addr = '0, a0_maddr;
  logic        a0_fill = 1'b0, a0_mode = 1'b0, a0_mread, a0_wr = 1'b0, a0_rvalid = 1'b0;
  logic [63:0] a0_rdata = '0;
  logic [8:0]  a0_full = '0, a0_en;
  logic [7:0]  a0_data;
  logic        a0_busy, a0_done;

  feed_from_mem_stream dut0 (
    .clk(clk), .rst(rst), .addr(a0_addr), .fill(a0_fill), .mode(a0_mode),
    .mem_addr(a0_maddr), .mem_read(a0_mread), .mem_waitrequest(a0_wr),
    .mem_readdata(a0_rdata), .mem_readdatavalid(a0_rvalid), .fifo_full(a0_full),
    .dataByte(a0_data), .fifoEnable(a0_en), .busy(a0_busy), .done(a0_done));

  // ---------------- 3 FIFOs x 5 bytes ----------------
  logic [31:0] a1_addr = '0, a1_maddr;
  logic        a1_fill = 1'b0, a1_mode = 1'b0, a1_mread, a1_wr = 1'b0, a1_rvalid = 1'b0;
  logic [63:0] a1_rdata = '0;
  logic [2:0]  a1_full = '0, a1_en;
  logic [7:0]  a1_data;
  logic        a1_busy, a1_done;

  feed_from_mem_stream #(.NUM_FIFOS(3), .DEPTH(5)) dut1 (
    .clk(clk), .rst(rst), .addr(a1_addr), .fill(a1_fill), .mode(a1_mode),
    .mem_addr(a1_maddr), .mem_read(a1_mread), .mem_waitrequest(a1_wr),
    .mem_readdata(a1_rdata), .mem_readdatavalid(a1_rvalid), .fifo_full(a1_full),
    .dataByte(a1_data), .fifoEnable(a1_en), .busy(a1_busy), .done(a1_done));

  // ---------------- memory responders (latency 1) ----------------
  int st_req0 = 0, st_used0 = 0, inj_req0 = 0, inj_done0 = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic [31:0] paddr0 = '0, paddr1 = '0;
  logic [31:0] acc0[$], acc1[$];

  always @(negedge clk) begin
    a0_rvalid = pend0;
    a0_rdata  = memword(paddr0);
    if (inj_done0 < inj_req0) begin
      a0_rvalid = 1'b1;
      a0_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
      inj_done0++;
    end
    pend0 = 1'b0;
    a0_wr = a0_mread && (st_used0 < st_req0);
    if (a0_wr) st_used0++;
    if (a0_mread && !a0_wr) begin
      pend0  = 1'b1;
      paddr0 = a0_maddr;
      acc0.push_back(a0_maddr);
    end
  end

  always @(negedge clk) begin
    a1_rvalid = pend1;
    a1_rdata  = memword(paddr1);
    pend1 = 1'b0;
    if (a1_mread) begin
      pend1  = 1'b1;
      paddr1 = a1_maddr;
      acc1.push_back(a1_maddr);
    end
  end

  // ---------------- model queues and per-cycle compare ----------------
  int q0f[$], q0d[$], q1f[$], q1d[$];
  int obs0[9][$], obs1[3][$];
  int wr0 = 0, wr1 = 0, dn0 = 0, dn1 = 0, hold0 = 0;

  always @(negedge clk) begin : cmp
    int f;
    #2;
    if (a0_en != 0) begin
      f = 0;
      for (int i = 0; i < 9; i++) if (a0_en[i]) f = i;
      check("d0_onehot", longint'($onehot(a0_en)), 1);
      if (q0f.size() == 0) check("d0_unexpected_write", a0_en, 0);
      else begin
        check("d0_fifo", f, q0f.pop_front());
        check("d0_byte", a0_data, q0d.pop_front());
      end
      obs0[f].push_back(int'(a0_data));
      wr0++;
    end else if (a0_busy && a0_data == 8'd16) hold0++;
    if (a0_done) begin
      dn0++;
      check("d0_busy_in_done", a0_busy, 1);
    end
    if (a1_en != 0) begin
      f = 0;
      for (int i = 0; i < 3; i++) if (a1_en[i]) f = i;
      check("d1_onehot", longint'($onehot(a1_en)), 1);
      if (q1f.size() == 0) check("d1_unexpected_write", a1_en, 0);
      else begin
        check("d1_fifo", f, q1f.pop_front());
        check("d1_byte", a1_data, q1d.pop_front());
      end
      obs1[f].push_back(int'(a1_data));
      wr1++;
    end
    if (a1_done) dn1++;
  end

  // Expected write sequence for the default geometry, straight from the byte-stream rules.
  task automatic push0(input logic [31:0] base, input logic md);
    logic [63:0] w;
    for (int b = 0; b < 72; b++) begin
      w = memword(base + 32'(b / 8));
      q0f.push_back(md ? b % 9 : b / 8);
      q0d.push_back(int'(w[8*(b%8) +: 8]));
    end
  endtask

  task automatic run0(input logic [31:0] base, input logic md, input int stalls,
                      input bit bp, input bit intr, output int cyc);
    int bad;
    st_req0 = st_used0 + stalls;
    acc0.delete();
    wr0 = 0; dn0 = 0; hold0 = 0;
    for (int i = 0; i < 9; i++) obs0[i].delete();
    push0(base, md);
    a0_addr = base; a0_mode = md; a0_fill = 1'b1;
    @(negedge clk);
    a0_fill = 1'b0;
    check("d0_busy_start", a0_busy, 1);
    cyc = 1;
    fork
      begin
        while (!a0_done && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
      end
      begin
        if (bp) begin
          int n = 0;
          while (!(a0_data == 8'd16 && a0_en != 0) && n < 400) begin
            @(negedge clk);
            n++;
          end
          a0_full[2] = 1'b1;
          repeat (5) @(negedge clk);
          a0_full[2] = 1'b0;
        end
      end
      begin
        if (intr) begin
          repeat (20) @(negedge clk);
          a0_addr = 32'h5000; a0_mode = ~md; a0_fill = 1'b1;
          @(negedge clk);
          a0_fill = 1'b0; a0_addr = base; a0_mode = md;
        end
      end
    join
    repeat (3) @(negedge clk);
    check("d0_model_drained", q0f.size(), 0);
    check("d0_done_count", dn0, 1);
    check("d0_reads", acc0.size(), 9);
    bad = 0;
    foreach (acc0[k]) if (acc0[k] != base + 32'(k)) bad++;
    check("d0_addr_seq", bad, 0);
    check("d0_writes", wr0, 72);
    check("d0_busy_after", a0_busy, 0);
  endtask

  initial begin
    int cyc, bad, n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_read", a0_mread, 0);
    check("rst_mem_addr", a0_maddr, 0);
    check("rst_fifo_en", a0_en, 0);
    check("rst_data", a0_data, 0);
    check("rst_busy", a0_busy, 0);
    check("rst_done", a0_done, 0);
    check("rst_d1_en", a1_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // sequential
    run0(32'h100, 1'b0, 0, 1'b0, 1'b0, cyc);
    check("seq_cycles", cyc, 91);
    check("seq_f3_first", obs0[3].size() > 0 ? obs0[3][0] : -1, 24);
    check("seq_f3_last", obs0[3].size() > 7 ? obs0[3][7] : -1, 31);
    bad = 0;
    for (int f = 0; f < 9; f++) if (obs0[f].size() != 8) bad++;
    check("seq_per_fifo", bad, 0);

    // interleaved
    run0(32'h100, 1'b1, 0, 1'b0, 1'b0, cyc);
    check("int_cycles", cyc, 91);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (obs0[0].size() <= i || obs0[0][i] != 9 * i) bad++;
      if (obs0[8].size() <= i || obs0[8][i] != 8 + 9 * i) bad++;
    end
    check("int_f0_f8_bytes", bad, 0);

    // waitrequest on first read plus FIFO 2 full while byte 16 is presented
    run0(32'h100, 1'b0, 3, 1'b1, 1'b0, cyc);
    check("bp_cycles", cyc, 99);
    check("bp_hold_cycles", hold0, 5);

    // fill while busy is ignored
    run0(32'h100, 1'b0, 0, 1'b0, 1'b1, cyc);
    check("busy_fill_cycles", cyc, 91);

    // partial final word
    wr1 = 0; dn1 = 0; acc1.delete();
    for (int b = 0; b < 15; b++) begin
      logic [63:0] w;
      w = memword(32'h100 + 32'(b / 8));
      q1f.push_back(b / 5);
      q1d.push_back(int'(w[8*(b%8) +: 8]));
    end
    a1_addr = 32'h100; a1_mode = 1'b0; a1_fill = 1'b1;
    @(negedge clk);
    a1_fill = 1'b0;
    cyc = 1;
    while (!a1_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("part_cycles", cyc, 20);
    check("part_writes", wr1, 15);
    check("part_done_count", dn1, 1);
    check("part_reads", acc1.size(), 2);
    check("part_model_drained", q1f.size(), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) if (obs1[2].size() <= i || obs1[2][i] != 10 + i) bad++;
    check("part_f2_bytes", bad, 0);

    // reset in the middle of word 4
    wr0 = 0;
    push0(32'h100, 1'b0);
    a0_addr = 32'h100; a0_mode = 1'b0; a0_fill = 1'b1;
    @(negedge clk);
    a0_fill = 1'b0;
    n = 0;
    while (!(a0_data == 8'd34 && a0_en != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_word4", n < 400, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0f.delete(); q0d.delete();
    check("mid_rst_mem_read", a0_mread, 0);
    check("mid_rst_mem_addr", a0_maddr, 0);
    check("mid_rst_fifo_en", a0_en, 0);
    check("mid_rst_data", a0_data, 0);
    check("mid_rst_busy", a0_busy, 0);
    check("mid_rst_done", a0_done, 0);
    inj_req0++;
    repeat (4) @(negedge clk);
    check("late_valid_ignored_busy", a0_busy, 0);
    run0(32'h203, 1'b0, 0, 1'b0, 1'b0, cyc);
    check("restart_cycles", cyc, 91);
    check("restart_f0_first", obs0[0].size() > 0 ? obs0[0][0] : -1, 'h18);
    check("restart_f8_last", obs0[8].size() > 7 ? obs0[8][7] : -1, 'h5F);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
